// File: rtl/prog_loader_if.sv
// Port bundle between the program loader, its word source and the processor it feeds.
// The loader itself connects through the slave modport; the driving side uses master.
interface prog_loader_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              start;
    logic [ADDR_W:0]   len;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              abort;
    logic              cpu_halted;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              cpu_run;
    logic              done;
    logic              err;
    logic [DATA_W-1:0] checksum;

    modport slave (
        input  start, len, in_valid, in_data, abort, cpu_halted,
        output in_ready, mem_we, mem_addr, mem_wdata, cpu_run, done, err, checksum
    );

    modport master (
        output start, len, in_valid, in_data, abort, cpu_halted,
        input  in_ready, mem_we, mem_addr, mem_wdata, cpu_run, done, err, checksum
    );
endinterface

// File: rtl/prog_loader.sv
// Streams a program image into the processor's memory, then releases the processor
// until it halts. Writes are registered one cycle behind acceptance.
module prog_loader #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input logic          clk1,
    input logic          rst,
    prog_loader_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_RUN   = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] LEN_MAX = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] LEN_ONE = {{ADDR_W{1'b0}}, 1'b1};

    state_t            r_state, w_state_next;
    logic [ADDR_W-1:0] r_cnt, w_cnt_next;
    logic [ADDR_W:0]   r_len, w_len_next;
    logic [DATA_W-1:0] r_checksum, w_checksum_next;
    logic              r_mem_we, w_mem_we_next;
    logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_next;
    logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata_next;
    logic              r_done, w_done_next;
    logic              r_err, w_err_next;

    logic w_len_ok;
    logic w_accept;
    logic w_last;

    assign w_len_ok = (bus.len != '0) && (bus.len <= LEN_MAX);
    assign w_accept = (r_state == ST_LOAD) && bus.in_valid;
    // Compare one bit wider than the counter so a full-memory load ends on its wrap.
    assign w_last   = (({1'b0, r_cnt} + LEN_ONE) == r_len);

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_len       <= '0;
            r_checksum  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_len       <= w_len_next;
            r_checksum  <= w_checksum_next;
            r_mem_we    <= w_mem_we_next;
            r_mem_addr  <= w_mem_addr_next;
            r_mem_wdata <= w_mem_wdata_next;
            r_done      <= w_done_next;
            r_err       <= w_err_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_cnt_next       = r_cnt;
        w_len_next       = r_len;
        w_checksum_next  = r_checksum;
        w_mem_we_next    = 1'b0;
        w_mem_addr_next  = r_mem_addr;
        w_mem_wdata_next = r_mem_wdata;
        w_done_next      = 1'b0;
        w_err_next       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    if (w_len_ok) begin
                        w_state_next    = ST_LOAD;
                        w_cnt_next      = '0;
                        w_checksum_next = '0;
                        w_len_next      = bus.len;
                    end else begin
                        w_err_next = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                // Abort wins over a word offered in the same cycle: nothing is written.
                if (bus.abort) begin
                    w_state_next = ST_IDLE;
                    w_err_next   = 1'b1;
                end else if (w_accept) begin
                    w_mem_we_next    = 1'b1;
                    w_mem_addr_next  = r_cnt;
                    w_mem_wdata_next = bus.in_data;
                    w_cnt_next       = r_cnt + 1'b1;
                    w_checksum_next  = r_checksum + bus.in_data;
                    if (w_last) begin
                        w_state_next = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                w_state_next = ST_RUN;
            end
            ST_RUN: begin
                if (bus.cpu_halted) begin
                    w_state_next = ST_IDLE;
                    w_done_next  = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign bus.in_ready  = (r_state == ST_LOAD);
    assign bus.cpu_run   = (r_state == ST_RUN);
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.done      = r_done;
    assign bus.err       = r_err;
    assign bus.checksum  = r_checksum;
endmodule
